// File: rtl/mips_loader_pkg.sv
// Shared state encodings and protocol constants for the UART boot loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERR} ld_state_e;

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} rx_state_e;

  localparam int LEN_BYTES = 2;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchroniser, mid-bit sampling, one-cycle byte/frame-error pulses.
module uart_rx_byte
  import mips_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          valid_q, ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Edge detect rather than level so a held-low line cannot retrigger.
          if (prev_q && !sync2_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? IDLE : BITS;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BITS: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            valid_q <= sync2_q;
            ferr_q  <= !sync2_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_mem_loader.sv
// Boot loader: receives a length-prefixed word image over UART and writes it to RAM,
// holding the CPU in reset until the image is complete.
module uart_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BPW          = DATA_WIDTH / 8;
  localparam int BCW          = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int IW           = ADDR_WIDTH + 1;
  localparam int LW           = 8 * LEN_BYTES;
  localparam logic [BCW-1:0] LAST_LANE = BCW'(BPW - 1);
  localparam logic [31:0]    CAPACITY  = 32'd1 << ADDR_WIDTH;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr)
  );

  ld_state_e             state_q;
  logic [LW-1:0]         len_q;
  logic [IW-1:0]         word_idx_q;
  logic [BCW-1:0]        byte_cnt_q;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  last_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  cpu_hold_q, done_q, error_q;
  logic [LW-1:0]         n_full;

  assign n_full = {rx_byte, len_q[7:0]};

  always_comb begin
    word_d = word_q;
    word_d[8*byte_cnt_q +: 8] = rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LEN_LO;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      last_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (rx_ferr && state_q != DONE) begin
        state_q <= ERR;
        error_q <= 1'b1;
      end else begin
        case (state_q)
          LEN_LO: begin
            if (rx_valid) begin
              len_q[7:0] <= rx_byte;
              state_q    <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (rx_valid) begin
              len_q[LW-1:8] <= rx_byte;
              if (n_full == '0) begin
                state_q    <= DONE;
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
              end else if (32'(n_full) > CAPACITY) begin
                state_q <= ERR;
                error_q <= 1'b1;
              end else begin
                state_q <= DATA;
              end
            end
          end
          DATA: begin
            // The final write is already on the port; release the CPU one cycle later.
            if (last_q) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else if (rx_valid) begin
              word_q <= word_d;
              if (byte_cnt_q == LAST_LANE) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= word_idx_q[ADDR_WIDTH-1:0];
                mem_wdata_q <= word_d;
                word_idx_q  <= word_idx_q + 1'b1;
                byte_cnt_q  <= '0;
                last_q      <= (32'(word_idx_q) + 32'd1 == 32'(len_q));
              end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end
            end
          end
          DONE, ERR: ;
          default: begin
            state_q <= ERR;
            error_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed and randomized bench for uart_mem_loader with a byte-stream reference model.
module tb_uart_mem_loader;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold, done, error;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_rise[$];
  logic        done_prev = 1'b0;

  logic [7:0]  sent[$];
  int          ferr_pos;

  uart_mem_loader #(
    .CLK_FREQ  (50000000),
    .BAUD      (5000000),
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (done && !done_prev) done_rise.push_back(cyc);
    done_prev <= done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_rise.delete();
    sent.delete();
    ferr_pos = -1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".we"},    64'(mem_we),    64'd0);
    check({tag, ".addr"},  64'(mem_addr),  64'd0);
    check({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, ".hold"},  64'(cpu_hold),  64'd1);
    check({tag, ".done"},  64'(done),      64'd0);
    check({tag, ".error"}, 64'(error),     64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
  endtask

  task automatic push_byte(input logic [7:0] b);
    sent.push_back(b);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sent.push_back(w[8*i +: 8]);
  endtask

  task automatic send_from(input int first);
    for (int i = first; i < sent.size(); i++) send_byte(sent[i], (i == ferr_pos) ? 1'b0 : 1'b1);
    tick(5);
  endtask

  task automatic glitch(input int n);
    rx = 1'b0;
    tick(n);
    rx = 1'b1;
    tick(3 * CPB);
  endtask

  // Expected outcome derived from the whole byte stream: length prefix, complete
  // little-endian words before any bad frame, sticky done/error.
  task automatic model_check(input string tag);
    int n, avail, nw;
    logic exp_done, exp_err;
    logic [31:0] w;
    n = 0; nw = 0; exp_done = 1'b0; exp_err = 1'b0;
    if (ferr_pos >= 0 && ferr_pos < 2) begin
      exp_err = 1'b1;
    end else if (sent.size() >= 2) begin
      n = int'(sent[0]) + 256 * int'(sent[1]);
      if (n > 1024) begin
        exp_err = 1'b1;
      end else begin
        avail = ((ferr_pos >= 0) ? ferr_pos : sent.size()) - 2;
        nw = (avail / 4 < n) ? avail / 4 : n;
        if (nw == n) exp_done = 1'b1;
        else if (ferr_pos >= 0) exp_err = 1'b1;
      end
    end
    check({tag, ".nwrites"}, 64'(wr_addr.size()), 64'(nw));
    for (int k = 0; k < nw && k < wr_addr.size(); k++) begin
      w = {sent[2+4*k+3], sent[2+4*k+2], sent[2+4*k+1], sent[2+4*k]};
      check($sformatf("%s.addr%0d", tag, k), 64'(wr_addr[k]), 64'(k));
      check($sformatf("%s.data%0d", tag, k), 64'(wr_data[k]), 64'(w));
    end
    check({tag, ".done"},  64'(done),     64'(exp_done));
    check({tag, ".error"}, 64'(error),    64'(exp_err));
    check({tag, ".hold"},  64'(cpu_hold), 64'(!exp_done));
  endtask

  initial begin
    logic [31:0] normal_words[10];
    int n_rand, base;
    normal_words = '{32'd9, 32'd5, 32'd7, 32'd8, 32'd1, 32'd3, 32'd5, 32'd7, 32'd8, 32'd4};
    ferr_pos = -1;

    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(3);
    clear_log();

    // Normal 10-word load
    push_byte(8'h0A); push_byte(8'h00);
    foreach (normal_words[i]) push_word(normal_words[i]);
    send_from(0);
    model_check("normal");
    check("normal.done_rises", 64'(done_rise.size()), 64'd1);
    if (done_rise.size() == 1 && wr_cyc.size() == 10)
      check("normal.done_lat", 64'(done_rise[0] - wr_cyc[9]), 64'd1);
    else
      check("normal.done_lat_seen", 64'(wr_cyc.size()), 64'd10);

    // Empty image
    do_reset();
    push_byte(8'h00); push_byte(8'h00);
    send_from(0);
    model_check("empty");

    // Framing error on second data byte, then a further valid byte
    do_reset();
    push_byte(8'h02); push_byte(8'h00); push_byte(8'h11); push_byte(8'h22);
    ferr_pos = 3;
    send_from(0);
    model_check("ferr");
    push_byte(8'h33);
    send_from(4);
    model_check("ferr.after");

    // Glitch must not be taken as a byte
    do_reset();
    glitch(3);
    push_byte(8'h00); push_byte(8'h00);
    send_from(0);
    model_check("glitch.empty");

    // Glitch then oversize length
    do_reset();
    glitch(3);
    push_byte(8'h01); push_byte(8'h04);
    push_word(32'h12345678);
    send_from(0);
    model_check("oversize");

    // Reset mid-word, then a clean one-word load
    do_reset();
    push_byte(8'h02); push_byte(8'h00); push_byte(8'hAA); push_byte(8'hBB);
    send_from(0);
    rst = 1'b1;
    tick(1);
    check_reset_vals("midrst");
    tick(1);
    rst = 1'b0;
    tick(2);
    clear_log();
    push_byte(8'h01); push_byte(8'h00);
    push_word(32'hDEADBEEF);
    send_from(0);
    model_check("deadbeef");
    if (wr_data.size() >= 1) check("deadbeef.value", 64'(wr_data[0]), 64'h0000_0000_DEAD_BEEF);
    else check("deadbeef.present", 64'(wr_data.size()), 64'd1);

    // Post-done traffic is ignored
    base = sent.size();
    for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
    send_from(base);
    model_check("postdone");

    // Randomized loads, the last with a random framing error inside the data
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n_rand = $urandom_range(1, 6);
      push_byte(8'(n_rand)); push_byte(8'h00);
      for (int k = 0; k < n_rand; k++) push_word($urandom);
      if (r == 3) ferr_pos = $urandom_range(2, sent.size() - 1);
      send_from(0);
      model_check($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
Boot-time loader that receives a word image over the UART rx line and writes it into processor RAM at consecutive addresses.
- Holds the MIPS core in reset until the image is fully written, then releases it.
- Replaces simulation-only hierarchical RAM preload with a synthesisable path.
- Generalised in word width, memory depth and baud rate.
- Sits in mips_top between the rx pin and the data-memory write port.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division)
DATA_WIDTH, 32, RAM word width; must be a multiple of 8; BYTES_PER_WORD = DATA_WIDTH/8
ADDR_WIDTH, 10, RAM word-address width; capacity = 2**ADDR_WIDTH words

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx  in  1  UART serial input, idle high, asynchronous to clk
mem_we  out  1  one-cycle RAM write strobe
mem_addr  out  ADDR_WIDTH  RAM word address
mem_wdata  out  DATA_WIDTH  RAM write data
cpu_hold  out  1  high = keep processor in reset
done  out  1  image fully written (sticky)
error  out  1  framing or length error (sticky)

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0. All internal counters and the FSM clear; any partial byte or word is discarded. RAM contents are not touched.
- rx passes through a 2-flop synchroniser, preset to 1 on reset.
- Byte receiver (8N1, LSB first):
  - Falling edge of synced rx in idle starts a byte.
  - Re-sample at CLKS_PER_BIT/2. If high, treat as a false start and return to idle.
  - Sample 8 data bits, each CLKS_PER_BIT apart, then the stop bit.
  - Stop bit = 1: byte_valid pulses for 1 cycle with the byte.
  - Stop bit = 0: frame_err pulses for 1 cycle.
- Protocol: 2-byte little-endian word count N, then N words, each sent as BYTES_PER_WORD bytes, little-endian.
- Loader FSM states: LEN_LO, LEN_HI, DATA, DONE, ERR.
  - LEN_LO: on byte_valid, latch N[7:0] and go to LEN_HI.
  - LEN_HI: on byte_valid, latch N[15:8].
    - N == 0: go to DONE.
    - N > 2**ADDR_WIDTH: go to ERR.
    - Otherwise: go to DATA.
  - DATA: shift each byte into the word register at lane byte_cnt.
    - On the last byte of a word: the next cycle drives mem_we=1, mem_addr=word_idx and mem_wdata=the assembled word for exactly 1 cycle.
    - word_idx then increments and byte_cnt clears.
    - Once the write of word N-1 has been issued, go to DONE on the following cycle.
  - DONE: done=1, cpu_hold=0. All further rx bytes are ignored and no writes occur.
  - ERR: error=1, cpu_hold stays 1, no writes. Left only via reset.
- frame_err in any state other than DONE goes to ERR.
- word_idx never wraps. With N == 2**ADDR_WIDTH, the last write goes to address 2**ADDR_WIDTH-1.
- Latency: mem_we asserts 1 cycle after the stop-bit sample of the final byte of each word.
- Simultaneous rst and byte_valid: reset wins.
- Reset in any state aborts the load. Words already written stay in RAM.

Decomposition:
- Package mips_loader_pkg holds:
  - FSM state encoding: LEN_LO, LEN_HI, DATA, DONE, ERR.
  - Receiver state encoding: IDLE, START, BITS, STOP.
  - Constant LEN_BYTES = 2.
- Sub-module uart_rx_byte contains the synchroniser, start/bit/stop sampling, byte_valid and frame_err. It is parametrised on CLKS_PER_BIT.
- uart_mem_loader contains the length/word FSM and the RAM-side outputs.

Test Plan:
(Bench settings for all scenarios: CLK_FREQ=50000000, BAUD=5000000, i.e. 10 clocks/bit; DATA_WIDTH=32; ADDR_WIDTH=10.)
- Normal load: send N=10 (bytes 0x0A 0x00), then words 9,5,7,8,1,3,5,7,8,4 -> exactly 10 mem_we pulses at addresses 0..9 with those values; done=1 and cpu_hold=0 one cycle after the 10th write; error=0.
- Empty image: send 0x00 0x00 -> no mem_we; done=1 and cpu_hold=0 after the second stop bit.
- Framing error: send N=2, then the second data byte with stop bit 0 -> error=1, cpu_hold=1, no mem_we for the partial word; a further valid byte causes no change.
- Glitch and oversize length: a 3-cycle low pulse on rx -> no byte accepted. Then send N=1025 (0x01 0x04) -> error=1, no mem_we.
- Reset mid-word: send N=2 and 2 bytes of word 0, then pulse rst -> outputs return to reset values. Then send N=1 and 0xDEADBEEF (EF BE AD DE) -> one write of 0xDEADBEEF at address 0, then done=1.
- Post-done traffic: after a completed N=1 load, send 8 more bytes -> no mem_we, and done, cpu_hold and error are unchanged.
